polar_result_packer: RTL and testbench
======================================

Name: polar_result_packer

Overview:
- Downstream of the integer ALU on the polar-decoding path. Consumes the 8-bit results of PL_F, PL_ADDSAT, PL_SUBSAT and PL_R (result bits [7:0], upper bits always zero).
- Byte mode (LLRs): packs 4 results per 32-bit word. Bit mode (PL_R hard decisions): packs 32 results per word.
- Queues closed words in a small FIFO and hands them to the store/writeback side over a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 4, number of 32-bit words buffered (power of two, >=2).
- CNT_W, 6, width of the element-count field (holds values up to 32).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous reset, active high.
- flush_i  in  1  synchronous discard of all buffered and partial data.
- in_valid_i  in  1  ALU polar result valid.
- in_ready_o  out  1  packer accepts a beat this cycle.
- in_data_i  in  8  ALU result[7:0]; bit mode uses bit 0 only.
- in_mode_i  in  1  0 = byte (LLR), 1 = bit (hard decision).
- in_last_i  in  1  closes the current word after this beat.
- out_valid_o  out  1  head-of-FIFO word valid.
- out_ready_i  in  1  consumer takes the word.
- out_data_o  out  32  packed word; first element at LSB.
- out_cnt_o  out  CNT_W  number of valid elements (1..4 in byte mode, 1..32 in bit mode).
- out_mode_o  out  1  mode of the word.
- out_last_o  out  1  word was closed by in_last_i.
- fifo_count_o  out  $clog2(FIFO_DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset (async, rst_i=1): accumulator data, count and mode = 0; FIFO empty. Outputs: out_valid_o=0, out_data_o=0, out_cnt_o=0, out_mode_o=0, out_last_o=0, fifo_count_o=0, in_ready_o=0. Reset asserted mid-operation discards everything; no partial word survives.
- Accept condition: a beat is accepted when in_valid_i && in_ready_o.
- in_ready_o = !rst_i && !flush_i && (fifo_count < FIFO_DEPTH) && !mode_conflict. It is conservative: a pop in the same cycle does not free a slot for a push.
- Accumulator, byte mode: element k (0..3) is written to bits [8k+7:8k]; count increments.
- Accumulator, bit mode: element k (0..31) is written to bit k; in_data_i[7:1] is ignored.
- Word close: the word closes on the accepted beat that makes count reach 4 (byte mode) or 32 (bit mode), or on any accepted beat with in_last_i=1.
  - The closed word (data including that beat, count, mode, last flag) is pushed into the FIFO in the same cycle.
  - The accumulator clears. Unused bytes/bits in the word are zero.
- Mode conflict: in_valid_i=1, accumulator count>0 and in_mode_i differs from the accumulator mode.
  - in_ready_o=0 that cycle; the partial word is pushed with out_last_o=0 (provided FIFO not full); the accumulator clears.
  - The beat is accepted on a later cycle. A conflict with a full FIFO stalls until space frees.
- Latency: closing beat accepted in cycle N -> word visible on out_* in cycle N+1 if the FIFO was empty. A pop occurs when out_valid_o && out_ready_i.
- Simultaneous push and pop: both happen; fifo_count_o is unchanged; pointers wrap modulo FIFO_DEPTH.
- Output stability: out_* hold stable while out_valid_o=1 && out_ready_i=0. out_* show zeros when the FIFO is empty.
- Flush: flush_i=1 in cycle N clears the FIFO and accumulator at the cycle-N edge. No accept and no pop take effect in cycle N; out_valid_o=0 from N+1.
- Count arithmetic: byte count saturates at 4, bit count at 32, by construction (the closing beat always pushes).

Test Plan:
- Byte mode: 4 beats 0x05, 0xFB, 0x7F, 0x81 back-to-back, out_ready_i=1 -> one word, out_data_o=0x817FFB05, out_cnt_o=4, out_mode_o=0, out_last_o=0, one cycle after the 4th accept.
- Bit mode: 32 beats alternating 1,0 -> out_data_o=0x55555555, out_cnt_o=32, out_mode_o=1. Then 3 bits 1,1,0 with in_last_i on the 3rd -> out_data_o=0x00000003, out_cnt_o=3, out_last_o=1.
- Mode conflict: 2 byte beats 0x11, 0x22 followed by a bit beat (value 1) -> in_ready_o=0 for one cycle.
  - First word: out_data_o=0x00002211, out_cnt_o=2, out_mode_o=0.
  - Bit beat accepted next cycle.
- Backpressure: out_ready_i=0 while 4*FIFO_DEPTH byte beats are offered -> fifo_count_o reaches 4, in_ready_o drops, the head word is held stable.
  - Raise out_ready_i -> words drain in order with no loss or duplication; a concurrent push/pop keeps fifo_count_o constant.
- Flush: FIFO holding 2 words plus a 3-byte partial, pulse flush_i -> next cycle out_valid_o=0, fifo_count_o=0.
  - The next 4 bytes form a fresh word with out_cnt_o=4.
- Reset mid-word: assert rst_i asynchronously between clock edges with 2 bytes accumulated -> all outputs zero immediately.
  - After release, the first 4 beats produce a word containing only post-reset data.

Source files
------------

// File: rtl/polar_result_packer.sv
// rtl/polar_result_packer.sv - packs 8-bit polar ALU results into 32-bit words
// Byte mode packs 4 LLRs per word, bit mode packs 32 hard decisions; closed words queue in a FIFO.
module polar_result_packer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 6
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          flush_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [7:0]                    in_data_i,
    input  logic                          in_mode_i,
    input  logic                          in_last_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [31:0]                   out_data_o,
    output logic [CNT_W-1:0]              out_cnt_o,
    output logic                          out_mode_o,
    output logic                          out_last_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int FC_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] BYTE_MAX = CNT_W'(4);
    localparam logic [CNT_W-1:0] BIT_MAX  = CNT_W'(32);

    logic [31:0]      acc_data;
    logic [CNT_W-1:0] acc_cnt;
    logic             acc_mode;

    logic [31:0]      mem_data [FIFO_DEPTH];
    logic [CNT_W-1:0] mem_cnt  [FIFO_DEPTH];
    logic             mem_mode [FIFO_DEPTH];
    logic             mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [FC_W-1:0]  fifo_count;

    logic             full, mode_conflict, accept, close_word, conflict_push, push, pop;
    logic [31:0]      beat_bits, merged_data, push_data;
    logic [CNT_W-1:0] next_cnt, push_cnt;
    logic             push_mode, push_last;

    assign full          = (fifo_count == FC_W'(FIFO_DEPTH));
    assign mode_conflict = in_valid_i && (acc_cnt != '0) && (in_mode_i != acc_mode);
    assign in_ready_o    = !rst_i && !flush_i && !full && !mode_conflict;
    assign accept        = in_valid_i && in_ready_o;
    assign next_cnt      = acc_cnt + CNT_W'(1);
    assign close_word    = accept && (in_last_i || next_cnt == (in_mode_i ? BIT_MAX : BYTE_MAX));
    // A conflicting beat evicts the partial word; the beat itself waits a cycle.
    assign conflict_push = mode_conflict && !full && !flush_i;
    assign push          = close_word || conflict_push;
    assign pop           = out_valid_o && out_ready_i && !flush_i;

    always_comb begin
        beat_bits = '0;
        if (in_mode_i)
            beat_bits = 32'(in_data_i[0]) << acc_cnt[4:0];
        else
            beat_bits = {24'h0, in_data_i} << {acc_cnt[1:0], 3'b000};
        merged_data = acc_data | beat_bits;
    end

    always_comb begin
        push_data = merged_data;
        push_cnt  = next_cnt;
        push_mode = in_mode_i;
        push_last = in_last_i;
        if (conflict_push) begin
            push_data = acc_data;
            push_cnt  = acc_cnt;
            push_mode = acc_mode;
            push_last = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_data <= '0;
            acc_cnt  <= '0;
            acc_mode <= 1'b0;
        end else if (flush_i || push) begin
            acc_data <= '0;
            acc_cnt  <= '0;
            acc_mode <= 1'b0;
        end else if (accept) begin
            acc_data <= merged_data;
            acc_cnt  <= next_cnt;
            acc_mode <= in_mode_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)
                fifo_count <= fifo_count + FC_W'(1);
            else if (pop && !push)
                fifo_count <= fifo_count - FC_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_data[wr_ptr] <= push_data;
            mem_cnt[wr_ptr]  <= push_cnt;
            mem_mode[wr_ptr] <= push_mode;
            mem_last[wr_ptr] <= push_last;
        end
    end

    assign out_valid_o  = (fifo_count != '0);
    assign out_data_o   = out_valid_o ? mem_data[rd_ptr] : '0;
    assign out_cnt_o    = out_valid_o ? mem_cnt[rd_ptr]  : '0;
    assign out_mode_o   = out_valid_o && mem_mode[rd_ptr];
    assign out_last_o   = out_valid_o && mem_last[rd_ptr];
    assign fifo_count_o = fifo_count;
endmodule

// File: tb/tb_polar_result_packer.sv
// tb/tb_polar_result_packer.sv - directed bench for polar_result_packer
module tb_polar_result_packer;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [7:0]  in_data_i = 8'h00;
    logic        in_mode_i = 1'b0;
    logic        in_last_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_data_o;
    logic [5:0]  out_cnt_o;
    logic        out_mode_o;
    logic        out_last_o;
    logic [2:0]  fifo_count_o;

    int vectors = 0;
    int miscompares = 0;

    polar_result_packer #(.FIFO_DEPTH(4), .CNT_W(6)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .in_mode_i(in_mode_i), .in_last_i(in_last_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .out_cnt_o(out_cnt_o), .out_mode_o(out_mode_o), .out_last_o(out_last_o),
        .fifo_count_o(fifo_count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic word(input string tag, input logic [31:0] d, input int cnt, input logic m, input logic l);
        chk({tag, "_valid"}, 32'(out_valid_o), 32'd1);
        chk({tag, "_data"}, out_data_o, d);
        chk({tag, "_cnt"}, 32'(out_cnt_o), 32'(cnt));
        chk({tag, "_mode"}, 32'(out_mode_o), 32'(m));
        chk({tag, "_last"}, 32'(out_last_o), 32'(l));
    endtask

    task automatic empty(input string tag);
        chk({tag, "_valid"}, 32'(out_valid_o), 32'd0);
        chk({tag, "_data"}, out_data_o, 32'd0);
        chk({tag, "_count"}, 32'(fifo_count_o), 32'd0);
    endtask

    // Called at a negedge: drives one beat, expects it to be accepted at the next posedge.
    task automatic beat(input logic [7:0] d, input logic m, input logic l);
        in_valid_i = 1'b1;
        in_data_i  = d;
        in_mode_i  = m;
        in_last_i  = l;
        #1;
        chk("beat_ready", 32'(in_ready_o), 32'd1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
        in_data_i  = 8'h00;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        chk("rst_ready", 32'(in_ready_o), 32'd0);
        chk("rst_cnt", 32'(out_cnt_o), 32'd0);
        chk("rst_mode", 32'(out_mode_o), 32'd0);
        chk("rst_last", 32'(out_last_o), 32'd0);
        empty("rst");
        rst_i = 1'b0;
        step();

        // Byte mode word, visible one cycle after the closing beat
        out_ready_i = 1'b1;
        beat(8'h05, 1'b0, 1'b0);
        beat(8'hFB, 1'b0, 1'b0);
        beat(8'h7F, 1'b0, 1'b0);
        chk("byte_not_early", 32'(out_valid_o), 32'd0);
        beat(8'h81, 1'b0, 1'b0);
        idle();
        word("byte", 32'h817FFB05, 4, 1'b0, 1'b0);
        chk("byte_count", 32'(fifo_count_o), 32'd1);
        step();
        empty("byte_popped");

        // Bit mode full word, then a short word closed by last
        for (int k = 0; k < 32; k++)
            beat((k % 2 == 0) ? 8'h01 : 8'hFE, 1'b1, 1'b0);
        idle();
        word("bit32", 32'h55555555, 32, 1'b1, 1'b0);
        step();
        beat(8'h01, 1'b1, 1'b0);
        beat(8'h01, 1'b1, 1'b0);
        beat(8'h00, 1'b1, 1'b1);
        idle();
        word("bit3", 32'h00000003, 3, 1'b1, 1'b1);
        step();
        empty("bit_popped");

        // Mode conflict evicts the partial byte word
        beat(8'h11, 1'b0, 1'b0);
        beat(8'h22, 1'b0, 1'b0);
        in_valid_i = 1'b1;
        in_data_i  = 8'h01;
        in_mode_i  = 1'b1;
        #1;
        chk("conflict_ready", 32'(in_ready_o), 32'd0);
        step();
        word("conflict", 32'h00002211, 2, 1'b0, 1'b0);
        beat(8'h01, 1'b1, 1'b0);
        beat(8'h00, 1'b1, 1'b1);
        idle();
        word("after_conflict", 32'h00000001, 2, 1'b1, 1'b1);
        step();
        empty("conflict_popped");

        // Backpressure fills the FIFO
        out_ready_i = 1'b0;
        for (int i = 0; i < 16; i++)
            beat(8'(i), 1'b0, 1'b0);
        in_valid_i = 1'b1;
        in_data_i  = 8'hAA;
        in_mode_i  = 1'b0;
        #1;
        chk("full_ready", 32'(in_ready_o), 32'd0);
        chk("full_count", 32'(fifo_count_o), 32'd4);
        step();
        idle();
        word("held1", 32'h03020100, 4, 1'b0, 1'b0);
        step();
        word("held2", 32'h03020100, 4, 1'b0, 1'b0);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        #1;
        chk("pop1_count", 32'(fifo_count_o), 32'd3);
        word("pop1", 32'h07060504, 4, 1'b0, 1'b0);
        beat(8'hA0, 1'b0, 1'b0);
        beat(8'hA1, 1'b0, 1'b0);
        beat(8'hA2, 1'b0, 1'b0);
        out_ready_i = 1'b1;
        beat(8'hA3, 1'b0, 1'b0);
        out_ready_i = 1'b0;
        idle();
        chk("pushpop_count", 32'(fifo_count_o), 32'd3);
        word("pushpop", 32'h0B0A0908, 4, 1'b0, 1'b0);
        out_ready_i = 1'b1;
        #1;
        word("drain0", 32'h0B0A0908, 4, 1'b0, 1'b0);
        step();
        word("drain1", 32'h0F0E0D0C, 4, 1'b0, 1'b0);
        step();
        word("drain2", 32'hA3A2A1A0, 4, 1'b0, 1'b0);
        step();
        empty("drained");

        // Flush drops two words and a partial
        out_ready_i = 1'b0;
        for (int i = 0; i < 11; i++)
            beat(8'h50 + 8'(i), 1'b0, 1'b0);
        idle();
        chk("preflush_count", 32'(fifo_count_o), 32'd2);
        flush_i = 1'b1;
        #1;
        chk("flush_ready", 32'(in_ready_o), 32'd0);
        step();
        flush_i = 1'b0;
        #1;
        empty("flushed");
        beat(8'h31, 1'b0, 1'b0);
        beat(8'h32, 1'b0, 1'b0);
        beat(8'h33, 1'b0, 1'b0);
        beat(8'h34, 1'b0, 1'b0);
        idle();
        word("post_flush", 32'h34333231, 4, 1'b0, 1'b0);
        chk("post_flush_count", 32'(fifo_count_o), 32'd1);
        out_ready_i = 1'b1;
        step();
        empty("post_flush_popped");

        // Asynchronous reset mid-word
        out_ready_i = 1'b0;
        beat(8'h01, 1'b0, 1'b0);
        beat(8'h02, 1'b0, 1'b0);
        beat(8'h03, 1'b0, 1'b0);
        beat(8'h04, 1'b0, 1'b0);
        beat(8'hDE, 1'b0, 1'b0);
        beat(8'hAD, 1'b0, 1'b0);
        idle();
        word("pre_reset", 32'h04030201, 4, 1'b0, 1'b0);
        rst_i = 1'b1;
        #1;
        empty("async_rst");
        chk("async_rst_ready", 32'(in_ready_o), 32'd0);
        chk("async_rst_cnt", 32'(out_cnt_o), 32'd0);
        step();
        rst_i = 1'b0;
        #1;
        beat(8'h41, 1'b0, 1'b0);
        beat(8'h42, 1'b0, 1'b0);
        beat(8'h43, 1'b0, 1'b0);
        beat(8'h44, 1'b0, 1'b0);
        idle();
        word("post_reset", 32'h44434241, 4, 1'b0, 1'b0);
        chk("post_reset_count", 32'(fifo_count_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
